mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single 128-bit block memory port between the instruction cache and the data cache.
- Sits between both cache instances and main memory.
- Sequences one whole block transaction (read refill or write-back) per grant, with round-robin fairness.
- Provides per-requester completed-transaction counters for performance debug.

Parameters:
- ADDR_W, 28, block address width (word address minus 2 offset bits)
- DATA_W, 128, block data width
- CNT_W, 16, width of each saturating transaction counter

Ports:
- clk  input  1  system clock
- proc_reset  input  1  synchronous active-high reset
- i_mem_read  input  1  I-cache block read request
- i_mem_write  input  1  I-cache block write request
- i_mem_addr  input  ADDR_W  I-cache block address
- i_mem_wdata  input  DATA_W  I-cache write data
- i_mem_rdata  output  DATA_W  read data to I-cache
- i_mem_ready  output  1  completion pulse to I-cache
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same as the i_* ports, for the D-cache
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory block address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- mem_ready  input  1  memory completion, one-cycle pulse
- i_txn_cnt  output  CNT_W  completed I-cache transactions
- d_txn_cnt  output  CNT_W  completed D-cache transactions

Behaviour:
- Single clock clk. Reset proc_reset is synchronous and active-high.
- Requests are level-sensitive. A requester holds read or write plus addr/wdata until it sees its ready. A request is active when read|write is high.
- FSM states: IDLE, GRANT_I, GRANT_D. The state is registered.
- IDLE:
  - Only I requesting -> GRANT_I.
  - Only D requesting -> GRANT_D.
  - Both requesting -> grant the requester not in last_grant.
  - None requesting -> stay in IDLE.
  - In IDLE, all mem_* outputs are 0 and both *_mem_ready are 0.
- GRANT_x:
  - mem_read, mem_write, mem_addr and mem_wdata are driven combinationally from requester x's inputs.
  - The other requester's inputs are ignored.
- Completion:
  - In GRANT_x with mem_ready=1: x_mem_ready=1 in that same cycle (combinational, x only).
  - Next state is IDLE. last_grant<=x. x_txn_cnt increments, saturating at all-ones.
- Abort: in GRANT_x, if x deasserts both read and write while mem_ready=0, go to IDLE without counting and leave last_grant unchanged.
- mem_ready while in IDLE is ignored: no ready is routed and no counter changes.
- Grant latency: a request arriving in IDLE reaches the memory port on the next cycle.
- Minimum turnaround is one IDLE cycle between transactions. This lets a requester update its own state, e.g. D-cache write-back followed by refill re-arbitrates as a new request.
- Read data: i_mem_rdata and d_mem_rdata both carry mem_rdata unconditionally. Only the ready pulse qualifies the data.
- Read and write asserted together by one requester is illegal. Both are passed through unchanged and no checking is done.
- Reset values: state=IDLE, last_grant=I (so D wins the first conflict), both counters=0, all mem_* and *_mem_ready outputs 0.
- Reset mid-transaction: returns to IDLE at the edge; any in-flight memory access is abandoned and no ready is routed.

Test Plan:
- Single I read: i_mem_read=1, i_mem_addr=28'h0000010. Expect mem_read=1 and mem_addr=28'h0000010 from the next cycle. mem_ready is pulsed with mem_rdata=128'hA5..A5 -> i_mem_ready=1 same cycle, i_mem_rdata=128'hA5..A5, d_mem_ready=0, i_txn_cnt=1, then IDLE.
- Simultaneous first conflict after reset: I read at 28'h1, D write at 28'h2 with wdata=128'h1234. Expect GRANT_D first with mem_write=1, mem_addr=28'h2, mem_wdata=128'h1234. After its ready, one IDLE cycle, then GRANT_I with mem_read=1, mem_addr=28'h1.
- Round-robin: both requesters continuously requesting over 6 transactions -> grant order D,I,D,I,D,I; i_txn_cnt=3, d_txn_cnt=3.
- D write-back then refill: d_mem_write to 28'h5 completes, then d_mem_read to 28'h9 the next cycle while I is idle. Expect the write, one IDLE cycle, then the read; d_txn_cnt=2.
- Abort and stray ready: grant I, then drop i_mem_read before mem_ready -> IDLE with i_txn_cnt unchanged. mem_ready pulsed in IDLE -> no *_mem_ready and counters unchanged.
- Reset mid-grant: proc_reset=1 during GRANT_D with mem_write=1. Expect next cycle mem_write=0, state IDLE, counters 0. A subsequent I/D conflict is granted to D first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache-side block ports, the shared memory port and the
// per-requester transaction counters seen by the memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
);
    logic              i_mem_read;
    logic              i_mem_write;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic [CNT_W-1:0]  i_txn_cnt;
    logic [CNT_W-1:0]  d_txn_cnt;

    // Arbiter side: masters the memory port, serves both caches.
    modport master (
        input  i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        output i_mem_rdata, i_mem_ready,
        input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output d_mem_rdata, d_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output i_txn_cnt, d_txn_cnt
    );

    // Environment side: the two caches and main memory.
    modport slave (
        output i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        input  i_mem_rdata, i_mem_ready,
        output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  d_mem_rdata, d_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  i_txn_cnt, d_txn_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory port between the I-cache and
// D-cache; one whole block transaction per grant, with saturating counters.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           proc_reset,
    mem_arbiter_if.master  bus
);
    localparam int   N_REQ = 2;
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_grant;

    logic              w_req_rd    [N_REQ];
    logic              w_req_wr    [N_REQ];
    logic [ADDR_W-1:0] w_req_addr  [N_REQ];
    logic [DATA_W-1:0] w_req_wdata [N_REQ];
    logic              w_active    [N_REQ];
    logic              w_done      [N_REQ];
    logic [CNT_W-1:0]  r_cnt       [N_REQ];

    logic              w_granted;
    logic              w_sel;

    assign w_req_rd[REQ_I]    = bus.i_mem_read;
    assign w_req_wr[REQ_I]    = bus.i_mem_write;
    assign w_req_addr[REQ_I]  = bus.i_mem_addr;
    assign w_req_wdata[REQ_I] = bus.i_mem_wdata;
    assign w_req_rd[REQ_D]    = bus.d_mem_read;
    assign w_req_wr[REQ_D]    = bus.d_mem_write;
    assign w_req_addr[REQ_D]  = bus.d_mem_addr;
    assign w_req_wdata[REQ_D] = bus.d_mem_wdata;

    // Completion is gated by reset so an abandoned access never routes a ready.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_active[gi] = w_req_rd[gi] | w_req_wr[gi];
            assign w_done[gi]   = w_granted && (w_sel == 1'(gi))
                                  && bus.mem_ready && !proc_reset;

            always_ff @(posedge clk) begin
                if (proc_reset) begin
                    r_cnt[gi] <= '0;
                end else if (w_done[gi] && (r_cnt[gi] != '1)) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort leaves last_grant alone; only a completed transaction moves it.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_last_grant <= REQ_I;
        end else if (w_done[REQ_I]) begin
            r_last_grant <= REQ_I;
        end else if (w_done[REQ_D]) begin
            r_last_grant <= REQ_D;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_granted    = 1'b0;
        w_sel        = REQ_I;
        case (r_state)
            IDLE: begin
                if (w_active[REQ_I] && w_active[REQ_D]) begin
                    w_next_state = (r_last_grant == REQ_I) ? GRANT_D : GRANT_I;
                end else if (w_active[REQ_I]) begin
                    w_next_state = GRANT_I;
                end else if (w_active[REQ_D]) begin
                    w_next_state = GRANT_D;
                end
            end
            GRANT_I: begin
                w_granted = 1'b1;
                w_sel     = REQ_I;
                if (bus.mem_ready || !w_active[REQ_I]) begin
                    w_next_state = IDLE;
                end
            end
            GRANT_D: begin
                w_granted = 1'b1;
                w_sel     = REQ_D;
                if (bus.mem_ready || !w_active[REQ_D]) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.mem_read    = w_granted & w_req_rd[w_sel];
    assign bus.mem_write   = w_granted & w_req_wr[w_sel];
    assign bus.mem_addr    = w_granted ? w_req_addr[w_sel]  : '0;
    assign bus.mem_wdata   = w_granted ? w_req_wdata[w_sel] : '0;

    assign bus.i_mem_ready = w_done[REQ_I];
    assign bus.d_mem_ready = w_done[REQ_D];
    assign bus.i_mem_rdata = bus.mem_rdata;
    assign bus.d_mem_rdata = bus.mem_rdata;

    assign bus.i_txn_cnt   = r_cnt[REQ_I];
    assign bus.d_txn_cnt   = r_cnt[REQ_D];
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single transactions,
// scoreboard of expected memory transactions, and hand-written corner cases.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic proc_reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus.master)
    );

    typedef struct {
        logic          who;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    typedef struct {
        logic          who;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          exp_rd;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
    } vec_t;

    txn_t sb[$];
    txn_t mon_e;
    vec_t vecs[5];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   e_i = 0;
    int   e_d = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic complete(input logic who);
        if (who) e_d = sat_inc(e_d);
        else     e_i = sat_inc(e_i);
    endtask

    task automatic push(input logic who, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        txn_t t;
        t.who = who; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        sb.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_i(input logic rd, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.i_mem_read = rd; bus.i_mem_write = wr; bus.i_mem_addr = addr; bus.i_mem_wdata = wd;
    endtask

    task automatic set_d(input logic rd, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.d_mem_read = rd; bus.d_mem_write = wr; bus.d_mem_addr = addr; bus.d_mem_wdata = wd;
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_icnt"}, DW'(bus.i_txn_cnt), DW'(e_i));
        chk({name, "_dcnt"}, DW'(bus.d_txn_cnt), DW'(e_d));
    endtask

    task automatic pulse_ready(input logic [DW-1:0] rd);
        @(posedge clk); #1;
        bus.mem_rdata = rd;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_grant_seen"}, DW'(got), DW'(1));
    endtask

    task automatic serve(input string name, input logic who, input logic [AW-1:0] addr, input logic [DW-1:0] rd);
        wait_grant(name);
        chk({name, "_addr"}, DW'(bus.mem_addr), DW'(addr));
        pulse_ready(rd);
        complete(who);
    endtask

    // Scoreboard: every routed ready must match the oldest expected transaction.
    always @(negedge clk) begin
        if (bus.mem_ready && (bus.i_mem_ready || bus.d_mem_ready)) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected_ready: got i=%0b d=%0b required none", bus.i_mem_ready, bus.d_mem_ready);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_who", DW'(bus.d_mem_ready), DW'(mon_e.who));
                chk("sb_single_ready", DW'(bus.i_mem_ready & bus.d_mem_ready), DW'(0));
                chk("sb_addr", DW'(bus.mem_addr), DW'(mon_e.addr));
                chk("sb_write", DW'(bus.mem_write), DW'(mon_e.wr));
                chk("sb_read", DW'(bus.mem_read), DW'(!mon_e.wr));
                if (mon_e.wr) chk("sb_wdata", bus.mem_wdata, mon_e.wdata);
                chk("sb_rdata_i", bus.i_mem_rdata, mon_e.rdata);
                chk("sb_rdata_d", bus.d_mem_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 28'h0000010, 128'h0, {16{8'hA5}},
                    1'b1, 1'b0, 28'h0000010, 128'h0};
        vecs[1] = '{1'b1, 1'b1, 28'hFFFFFFF, {4{32'hCAFEF00D}}, 128'h0,
                    1'b0, 1'b1, 28'hFFFFFFF, {4{32'hCAFEF00D}}};
        vecs[2] = '{1'b1, 1'b0, 28'h0000000, {8{16'h5A5A}}, {16{8'h3C}},
                    1'b1, 1'b0, 28'h0000000, {8{16'h5A5A}}};
        vecs[3] = '{1'b0, 1'b1, 28'h8000001, {2{64'h0123456789ABCDEF}}, {16{8'hFF}},
                    1'b0, 1'b1, 28'h8000001, {2{64'h0123456789ABCDEF}}};
        vecs[4] = '{1'b0, 1'b0, 28'h7FFFFFF, 128'h0, {4{32'h600DBEEF}},
                    1'b1, 1'b0, 28'h7FFFFFF, 128'h0};

        set_i(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        proc_reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1 proc_reset = 1'b0;

        @(negedge clk);
        chk("rst_mem_read", DW'(bus.mem_read), DW'(0));
        chk("rst_mem_write", DW'(bus.mem_write), DW'(0));
        chk("rst_mem_addr", DW'(bus.mem_addr), DW'(0));
        chk("rst_mem_wdata", bus.mem_wdata, DW'(0));
        chk("rst_ready", DW'({bus.i_mem_ready, bus.d_mem_ready}), DW'(0));
        chk_cnt("rst");

        // First conflict after reset goes to D.
        tick();
        set_i(1, 0, 28'h1, '0);
        set_d(0, 1, 28'h2, 128'h1234);
        push(1, 1, 28'h2, 128'h1234, {16{8'h11}});
        push(0, 0, 28'h1, '0, {16{8'h22}});
        @(negedge clk);
        chk("conf_latency_idle", DW'(bus.mem_read | bus.mem_write), DW'(0));
        @(negedge clk);
        chk("conf_d_write", DW'(bus.mem_write), DW'(1));
        chk("conf_d_noread", DW'(bus.mem_read), DW'(0));
        chk("conf_d_addr", DW'(bus.mem_addr), DW'(28'h2));
        chk("conf_d_wdata", bus.mem_wdata, DW'(128'h1234));
        pulse_ready({16{8'h11}});
        complete(1);
        set_d(0, 0, '0, '0);
        @(negedge clk);
        chk("conf_turnaround_idle", DW'(bus.mem_read | bus.mem_write), DW'(0));
        @(negedge clk);
        chk("conf_i_read", DW'(bus.mem_read), DW'(1));
        chk("conf_i_addr", DW'(bus.mem_addr), DW'(28'h1));
        pulse_ready({16{8'h22}});
        complete(0);
        set_i(0, 0, '0, '0);
        @(negedge clk);
        chk_cnt("conf");

        // Table of single-requester transactions.
        for (int v = 0; v < 5; v++) begin
            tick();
            if (vecs[v].who) set_d(!vecs[v].wr, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            else             set_i(!vecs[v].wr, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            push(vecs[v].who, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].rdata);
            @(negedge clk);
            chk($sformatf("vec%0d_latency_idle", v), DW'(bus.mem_read | bus.mem_write), DW'(0));
            @(negedge clk);
            chk($sformatf("vec%0d_read", v), DW'(bus.mem_read), DW'(vecs[v].exp_rd));
            chk($sformatf("vec%0d_write", v), DW'(bus.mem_write), DW'(vecs[v].exp_wr));
            chk($sformatf("vec%0d_addr", v), DW'(bus.mem_addr), DW'(vecs[v].exp_addr));
            chk($sformatf("vec%0d_wdata", v), bus.mem_wdata, vecs[v].exp_wdata);
            chk($sformatf("vec%0d_no_early_ready", v), DW'({bus.i_mem_ready, bus.d_mem_ready}), DW'(0));
            @(posedge clk); #1;
            bus.mem_rdata = vecs[v].rdata;
            bus.mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_i_ready", v), DW'(bus.i_mem_ready), DW'(!vecs[v].who));
            chk($sformatf("vec%0d_d_ready", v), DW'(bus.d_mem_ready), DW'(vecs[v].who));
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            complete(vecs[v].who);
            set_i(0, 0, '0, '0);
            set_d(0, 0, '0, '0);
            @(negedge clk);
            chk($sformatf("vec%0d_back_idle", v), DW'(bus.mem_read | bus.mem_write), DW'(0));
            chk_cnt($sformatf("vec%0d", v));
        end

        // Round-robin with both requesting continuously; last grant was I.
        tick();
        set_i(1, 0, 28'h100, '0);
        set_d(1, 0, 28'h200, '0);
        for (int k = 0; k < 6; k++)
            push((k % 2) == 0, 1'b0, ((k % 2) == 0) ? 28'h200 : 28'h100, '0, DW'(k + 100));
        for (int k = 0; k < 6; k++)
            serve($sformatf("rr%0d", k), (k % 2) == 0, ((k % 2) == 0) ? 28'h200 : 28'h100, DW'(k + 100));
        set_i(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        @(negedge clk);
        chk_cnt("rr");

        // D write-back followed immediately by refill.
        tick();
        set_d(0, 1, 28'h5, {8{16'hBEEF}});
        push(1, 1, 28'h5, {8{16'hBEEF}}, '0);
        serve("wb", 1, 28'h5, '0);
        set_d(1, 0, 28'h9, '0);
        push(1, 0, 28'h9, '0, {16{8'h77}});
        @(negedge clk);
        chk("wb_turnaround_idle", DW'(bus.mem_read | bus.mem_write), DW'(0));
        @(negedge clk);
        chk("refill_read", DW'(bus.mem_read), DW'(1));
        chk("refill_addr", DW'(bus.mem_addr), DW'(28'h9));
        pulse_ready({16{8'h77}});
        complete(1);
        set_d(0, 0, '0, '0);
        @(negedge clk);
        chk_cnt("wb_refill");

        // Abort: I drops its request before mem_ready.
        tick();
        set_i(1, 0, 28'h77, '0);
        wait_grant("abort");
        chk("abort_addr", DW'(bus.mem_addr), DW'(28'h77));
        tick();
        set_i(0, 0, '0, '0);
        @(negedge clk);
        chk("abort_read_drop", DW'(bus.mem_read), DW'(0));
        @(negedge clk);
        chk_cnt("abort");

        // Stray mem_ready in IDLE.
        tick();
        bus.mem_rdata = {16{8'hEE}};
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("stray_no_ready", DW'({bus.i_mem_ready, bus.d_mem_ready}), DW'(0));
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk_cnt("stray");

        // Abort did not move last_grant (still D), so I wins this conflict.
        tick();
        set_i(1, 0, 28'h11, '0);
        set_d(1, 0, 28'h22, '0);
        push(0, 0, 28'h11, '0, {16{8'h44}});
        push(1, 0, 28'h22, '0, {16{8'h55}});
        serve("post_abort_i", 0, 28'h11, {16{8'h44}});
        set_i(0, 0, '0, '0);
        serve("post_abort_d", 1, 28'h22, {16{8'h55}});
        set_d(0, 0, '0, '0);
        @(negedge clk);
        chk_cnt("post_abort");

        // Reset in the middle of a D write grant.
        tick();
        set_d(0, 1, 28'h33, {16{8'h99}});
        wait_grant("rst_mid");
        chk("rst_mid_write", DW'(bus.mem_write), DW'(1));
        tick();
        proc_reset = 1'b1;
        tick();
        proc_reset = 1'b0;
        set_d(0, 0, '0, '0);
        e_i = 0;
        e_d = 0;
        @(negedge clk);
        chk("rst_mid_write_drop", DW'(bus.mem_write), DW'(0));
        chk("rst_mid_read_drop", DW'(bus.mem_read), DW'(0));
        chk_cnt("rst_mid");

        tick();
        set_i(1, 0, 28'h44, '0);
        set_d(1, 0, 28'h55, '0);
        push(1, 0, 28'h55, '0, {16{8'h66}});
        push(0, 0, 28'h44, '0, {16{8'h88}});
        serve("rst_conf_d", 1, 28'h55, {16{8'h66}});
        set_d(0, 0, '0, '0);
        serve("rst_conf_i", 0, 28'h44, {16{8'h88}});
        set_i(0, 0, '0, '0);

        // Drive the I counter past its all-ones limit.
        for (int k = 0; k < 17; k++) begin
            tick();
            set_i(1, 0, AW'(k + 1000), '0);
            push(0, 0, AW'(k + 1000), '0, DW'(k));
            serve($sformatf("sat%0d", k), 0, AW'(k + 1000), DW'(k));
            set_i(0, 0, '0, '0);
            @(negedge clk);
            chk($sformatf("sat%0d_icnt", k), DW'(bus.i_txn_cnt), DW'(e_i));
        end
        chk("sat_final_icnt", DW'(bus.i_txn_cnt), DW'(CNT_MAX));
        chk_cnt("final");
        chk("sb_empty", DW'(sb.size()), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
